rst_seq_wdog: RTL and testbench

//  Consumes the raw board/bench reset and produces staged, synchronised
//  per-domain resets for the LSTM datapath. Domain k is released in index order.

---
 rtl/rst_seq_wdog.sv | 153 +++++++++++++++
 tb/tb_rst_seq_wdog.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_wdog.sv
// Reset sequencer: synchronises the board reset, releases per-domain resets in
// index order, and re-sequences every domain on a soft request or watchdog expiry.
module rst_seq_wdog #(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_DOMAINS   = 3,
  parameter int STAGE_DLY     = 16,
  parameter int SW_RST_CYCLES = 8,
  parameter int WDOG_CYCLES   = 1000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   soft_rst_i,
  input  logic                   wdog_en_i,
  input  logic                   wdog_kick_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   ready_o,
  output logic                   wdog_timeout_o,
  output logic [1:0]             rst_cause_o
);

  typedef enum logic [1:0] {S_HOLD, S_SEQ, S_RUN, S_SOFT} state_t;

  localparam int SEQ_LEN = NUM_DOMAINS * STAGE_DLY;
  localparam int CNT_MAX = (SEQ_LEN > SW_RST_CYCLES) ? SEQ_LEN : SW_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WDOG_W  = $clog2(WDOG_CYCLES);

  localparam logic [CNT_W-1:0]  SEQ_LAST  = CNT_W'(SEQ_LEN);
  localparam logic [CNT_W-1:0]  SOFT_LAST = CNT_W'(SW_RST_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;

  // The HOLD->SEQ transition of the state register is the last synchroniser
  // flop, so the chain itself holds SYNC_STAGES-1 flops.
  logic [SYNC_STAGES-2:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [WDOG_W-1:0]      r_wdog;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic                   r_ready;
  logic                   r_timeout;
  logic [1:0]             r_cause;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [WDOG_W-1:0]      w_wdog_nxt;
  logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
  logic                   w_ready_nxt;
  logic                   w_timeout_nxt;
  logic [1:0]             w_cause_nxt;
  logic                   w_sync_ok;
  logic                   w_soft_evt;
  logic                   w_wdog_evt;

  assign w_sync_ok  = r_sync[SYNC_STAGES-2];
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_soft_evt = soft_rst_i && ((r_state == S_SEQ) || (r_state == S_RUN));
  // A kick or a soft request on the expiry cycle suppresses the timeout.
  assign w_wdog_evt = (r_state == S_RUN) && wdog_en_i && !wdog_kick_i &&
                      !soft_rst_i && (r_wdog == WDOG_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync    <= '0;
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_wdog    <= '0;
      r_rst_n   <= '0;
      r_ready   <= 1'b0;
      r_timeout <= 1'b0;
      r_cause   <= CAUSE_POR;
    end else begin
      r_sync[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES - 1; i++) r_sync[i] <= r_sync[i-1];
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wdog    <= w_wdog_nxt;
      r_rst_n   <= w_rst_n_nxt;
      r_ready   <= w_ready_nxt;
      r_timeout <= w_timeout_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HOLD: if (w_sync_ok) w_state_nxt = S_SEQ;
      S_SEQ: begin
        if (w_soft_evt)                  w_state_nxt = S_SOFT;
        else if (w_cnt_inc == SEQ_LAST) w_state_nxt = S_RUN;
      end
      S_RUN:  if (w_soft_evt || w_wdog_evt) w_state_nxt = S_SOFT;
      S_SOFT: if (w_cnt_inc == SOFT_LAST)   w_state_nxt = S_SEQ;
      default: w_state_nxt = S_HOLD;
    endcase
  end

  always_comb begin
    w_cnt_nxt     = '0;
    w_wdog_nxt    = '0;
    w_rst_n_nxt   = r_rst_n;
    w_ready_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_cause_nxt   = r_cause;
    case (r_state)
      S_HOLD: w_rst_n_nxt = '0;
      S_SEQ: begin
        if (w_soft_evt) begin
          w_rst_n_nxt = '0;
          w_cause_nxt = CAUSE_SOFT;
        end else begin
          if (w_cnt_inc != SEQ_LAST) w_cnt_nxt = w_cnt_inc;
          for (int k = 0; k < NUM_DOMAINS; k++)
            if (w_cnt_inc == CNT_W'((k + 1) * STAGE_DLY)) w_rst_n_nxt[k] = 1'b1;
          w_ready_nxt = (w_cnt_inc == SEQ_LAST);
        end
      end
      S_RUN: begin
        if (w_soft_evt) begin
          w_rst_n_nxt = '0;
          w_cause_nxt = CAUSE_SOFT;
        end else if (w_wdog_evt) begin
          w_rst_n_nxt   = '0;
          w_timeout_nxt = 1'b1;
          w_cause_nxt   = CAUSE_WDOG;
        end else begin
          w_ready_nxt = 1'b1;
          if (wdog_en_i && !wdog_kick_i) w_wdog_nxt = r_wdog + WDOG_W'(1);
        end
      end
      S_SOFT: begin
        w_rst_n_nxt = '0;
        if (w_cnt_inc != SOFT_LAST) w_cnt_nxt = w_cnt_inc;
      end
      default: w_rst_n_nxt = '0;
    endcase
  end

  assign rst_n_o        = r_rst_n;
  assign ready_o        = r_ready;
  assign wdog_timeout_o = r_timeout;
  assign rst_cause_o    = r_cause;

endmodule

// File: tb/tb_rst_seq_wdog.sv
// Directed bench for rst_seq_wdog: power-on staging, soft reset, watchdog
// expiry and kicks, expiry-cycle races, and asynchronous abort.
module tb_rst_seq_wdog;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       soft_rst_i;
  logic       wdog_en_i;
  logic       wdog_kick_i;
  logic [2:0] rst_n_o;
  logic       ready_o;
  logic       wdog_timeout_o;
  logic [1:0] rst_cause_o;

  // Observed vector: {rst_n_o[2:0], ready_o, wdog_timeout_o, rst_cause_o[1:0]}
  logic [6:0] obs;
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  assign obs = {rst_n_o, ready_o, wdog_timeout_o, rst_cause_o};

  always #5 clk_i = ~clk_i;

  rst_seq_wdog #(
    .SYNC_STAGES  (2),
    .NUM_DOMAINS  (3),
    .STAGE_DLY    (16),
    .SW_RST_CYCLES(8),
    .WDOG_CYCLES  (1000)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .soft_rst_i    (soft_rst_i),
    .wdog_en_i     (wdog_en_i),
    .wdog_kick_i   (wdog_kick_i),
    .rst_n_o       (rst_n_o),
    .ready_o       (ready_o),
    .wdog_timeout_o(wdog_timeout_o),
    .rst_cause_o   (rst_cause_o)
  );

  // cyc counts negedges; after step() the value is the index of the posedge just passed.
  task automatic step();
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; soft_rst_i = 1'b0; wdog_en_i = 1'b0; wdog_kick_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (obs !== 7'b000_0_0_00) begin
      errors++; $display("FAIL reset_state got=%b exp=%b", obs, 7'b000_0_0_00);
    end
  endtask

  // Ends at the negedge after the RUN-entry edge (edge 49), with cyc = 49.
  task automatic test_power_on(input bit soft_in_hold);
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1; soft_rst_i = soft_in_hold; cyc = -1;
    run_to(1); soft_rst_i = 1'b0;
    run_to(16); checks++;
    if (obs !== 7'b000_0_0_00) begin errors++; $display("FAIL po_e16 got=%b exp=%b", obs, 7'b000_0_0_00); end
    run_to(17); checks++;
    if (obs !== 7'b001_0_0_00) begin errors++; $display("FAIL po_e17 got=%b exp=%b", obs, 7'b001_0_0_00); end
    run_to(32); checks++;
    if (obs !== 7'b001_0_0_00) begin errors++; $display("FAIL po_e32 got=%b exp=%b", obs, 7'b001_0_0_00); end
    run_to(33); checks++;
    if (obs !== 7'b011_0_0_00) begin errors++; $display("FAIL po_e33 got=%b exp=%b", obs, 7'b011_0_0_00); end
    run_to(48); checks++;
    if (obs !== 7'b011_0_0_00) begin errors++; $display("FAIL po_e48 got=%b exp=%b", obs, 7'b011_0_0_00); end
    run_to(49); checks++;
    if (obs !== 7'b111_1_0_00) begin errors++; $display("FAIL po_e49 got=%b exp=%b", obs, 7'b111_1_0_00); end
  endtask

  // Each following task starts at the negedge after a RUN entry (cyc = 0 there).
  task automatic test_wdog_timeout();
    cyc = 0; wdog_en_i = 1'b1;
    run_to(999); checks++;
    if (obs !== 7'b111_1_0_00) begin errors++; $display("FAIL wd_pre got=%b exp=%b", obs, 7'b111_1_0_00); end
    run_to(1000); checks++;
    if (obs !== 7'b000_0_1_10) begin errors++; $display("FAIL wd_fire got=%b exp=%b", obs, 7'b000_0_1_10); end
    run_to(1001); checks++;
    if (obs !== 7'b000_0_0_10) begin errors++; $display("FAIL wd_pulse_end got=%b exp=%b", obs, 7'b000_0_0_10); end
    run_to(1024); checks++;
    if (obs !== 7'b001_0_0_10) begin errors++; $display("FAIL wd_reseq_d0 got=%b exp=%b", obs, 7'b001_0_0_10); end
    run_to(1056); checks++;
    if (obs !== 7'b111_1_0_10) begin errors++; $display("FAIL wd_reseq_run got=%b exp=%b", obs, 7'b111_1_0_10); end
    wdog_en_i = 1'b0;
  endtask

  task automatic test_soft();
    cyc = 0; soft_rst_i = 1'b1;
    run_to(1); soft_rst_i = 1'b0; checks++;
    if (obs !== 7'b000_0_0_01) begin errors++; $display("FAIL sf_assert got=%b exp=%b", obs, 7'b000_0_0_01); end
    run_to(3); soft_rst_i = 1'b1;
    run_to(6); soft_rst_i = 1'b0;
    run_to(24); checks++;
    if (obs !== 7'b000_0_0_01) begin errors++; $display("FAIL sf_e24 got=%b exp=%b", obs, 7'b000_0_0_01); end
    run_to(25); checks++;
    if (obs !== 7'b001_0_0_01) begin errors++; $display("FAIL sf_e25 got=%b exp=%b", obs, 7'b001_0_0_01); end
    run_to(41); checks++;
    if (obs !== 7'b011_0_0_01) begin errors++; $display("FAIL sf_e41 got=%b exp=%b", obs, 7'b011_0_0_01); end
    run_to(56); checks++;
    if (obs !== 7'b011_0_0_01) begin errors++; $display("FAIL sf_e56 got=%b exp=%b", obs, 7'b011_0_0_01); end
    run_to(57); checks++;
    if (obs !== 7'b111_1_0_01) begin errors++; $display("FAIL sf_e57 got=%b exp=%b", obs, 7'b111_1_0_01); end
  endtask

  task automatic test_soft_in_seq();
    cyc = 0; soft_rst_i = 1'b1;
    run_to(1); soft_rst_i = 1'b0;
    run_to(25); checks++;
    if (obs !== 7'b001_0_0_01) begin errors++; $display("FAIL ss_d0 got=%b exp=%b", obs, 7'b001_0_0_01); end
    run_to(30); soft_rst_i = 1'b1;
    run_to(31); soft_rst_i = 1'b0; checks++;
    if (obs !== 7'b000_0_0_01) begin errors++; $display("FAIL ss_abort got=%b exp=%b", obs, 7'b000_0_0_01); end
    run_to(54); checks++;
    if (obs !== 7'b000_0_0_01) begin errors++; $display("FAIL ss_e54 got=%b exp=%b", obs, 7'b000_0_0_01); end
    run_to(55); checks++;
    if (obs !== 7'b001_0_0_01) begin errors++; $display("FAIL ss_e55 got=%b exp=%b", obs, 7'b001_0_0_01); end
    run_to(87); checks++;
    if (obs !== 7'b111_1_0_01) begin errors++; $display("FAIL ss_e87 got=%b exp=%b", obs, 7'b111_1_0_01); end
  endtask

  task automatic test_kick();
    bit seen = 1'b0;
    cyc = 0; wdog_en_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      while (cyc < 999 * k - 1) begin step(); seen |= wdog_timeout_o; end
      wdog_kick_i = 1'b1;
      step(); seen |= wdog_timeout_o;
      wdog_kick_i = 1'b0;
    end
    while (cyc < 3996) begin step(); seen |= wdog_timeout_o; end
    wdog_en_i = 1'b0;
    step(); seen |= wdog_timeout_o;
    wdog_en_i = 1'b1;
    while (cyc < 4996) begin step(); seen |= wdog_timeout_o; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL kk_never_fired got=%b exp=%b", seen, 1'b0); end
    checks++;
    if (obs !== 7'b111_1_0_01) begin errors++; $display("FAIL kk_e4996 got=%b exp=%b", obs, 7'b111_1_0_01); end
    run_to(4997); checks++;
    if (obs !== 7'b000_0_1_10) begin errors++; $display("FAIL kk_fire_after_en got=%b exp=%b", obs, 7'b000_0_1_10); end
    run_to(5053); checks++;
    if (obs !== 7'b111_1_0_10) begin errors++; $display("FAIL kk_run got=%b exp=%b", obs, 7'b111_1_0_10); end
  endtask

  task automatic test_races();
    cyc = 0;
    run_to(999); checks++;
    if (obs !== 7'b111_1_0_10) begin errors++; $display("FAIL rk_e999 got=%b exp=%b", obs, 7'b111_1_0_10); end
    wdog_kick_i = 1'b1;
    run_to(1000); wdog_kick_i = 1'b0; checks++;
    if (obs !== 7'b111_1_0_10) begin errors++; $display("FAIL rk_kick_wins got=%b exp=%b", obs, 7'b111_1_0_10); end
    run_to(1999); soft_rst_i = 1'b1;
    run_to(2000); soft_rst_i = 1'b0; checks++;
    if (obs !== 7'b000_0_0_01) begin errors++; $display("FAIL rs_soft_wins got=%b exp=%b", obs, 7'b000_0_0_01); end
    run_to(2001); checks++;
    if (obs !== 7'b000_0_0_01) begin errors++; $display("FAIL rs_no_pulse got=%b exp=%b", obs, 7'b000_0_0_01); end
    run_to(2056); checks++;
    if (obs !== 7'b111_1_0_01) begin errors++; $display("FAIL rs_run got=%b exp=%b", obs, 7'b111_1_0_01); end
    wdog_en_i = 1'b0;
  endtask

  task automatic test_async_abort();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1; cyc = -1;
    run_to(20); checks++;
    if (obs !== 7'b001_0_0_00) begin errors++; $display("FAIL ab_mid got=%b exp=%b", obs, 7'b001_0_0_00); end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b000_0_0_00) begin errors++; $display("FAIL ab_async got=%b exp=%b", obs, 7'b000_0_0_00); end
    test_power_on(1'b0);
  endtask

  initial begin
    test_reset();
    test_power_on(1'b1);
    test_wdog_timeout();
    test_soft();
    test_soft_in_seq();
    test_kick();
    test_races();
    test_async_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
